fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions.
//   - Default word and address widths for fetch and decode.
//   - Opcode constants, taken from instruction bits [word_size-1 -: 4].
//   - Fetch state encoding.
package fetch_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int ADDR_DEF      = 16;

    localparam logic [3:0] OPC_NOP  = 4'b0000;
    localparam logic [3:0] OPC_JMP  = 4'b1100;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    function automatic logic is_halt(input logic [3:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush.
//   clk, rst_n   clock and synchronous active-low reset
//   push, din    enqueue (ignored when full unless a pop frees a slot)
//   pop          dequeue (ignored when empty)
//   flush        drop all entries
//   dout         head entry; when empty, holds the last value shown
//   full, empty, count  occupancy status
module fetch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [W-1:0]  last_q;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer can still push.
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    // Registered storage only: the head never reflects din in the same cycle.
    assign dout    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Tracks what dout showed last cycle so an empty buffer keeps presenting it.
    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= '0;
        else        last_q <= dout;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request control, fetch FSM and a
// small instruction buffer feeding decode.
//   DCLK, RST_N        clock, synchronous active-low reset
//   IREQ, IADDR        instruction memory read request / address
//   IDATA              read data, valid one cycle after IREQ
//   I_OUT, I_VLD, I_RDY  valid/ready instruction stream to decode
//   JMP_EN, JMP_TARGET redirect from decode
//   HALTED             fetch stopped on a HALT opcode
// Optional feature: define FETCH_HALT_EN to stop fetching when a HALT
// opcode is buffered; otherwise HALT is an ordinary instruction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     word_size   = WORD_SIZE_DEF,
    parameter int                     memory_addr = ADDR_DEF,
    parameter int                     buf_depth   = 2,
    parameter logic [memory_addr-1:0] reset_pc    = '0
) (
    input  logic                   DCLK,
    input  logic                   RST_N,
    output logic                   IREQ,
    output logic [memory_addr-1:0] IADDR,
    input  logic [word_size-1:0]   IDATA,
    output logic [word_size-1:0]   I_OUT,
    output logic                   I_VLD,
    input  logic                   I_RDY,
    input  logic                   JMP_EN,
    input  logic [memory_addr-1:0] JMP_TARGET,
    output logic                   HALTED
);

    localparam int AW = $clog2(buf_depth);
    localparam int CW = AW + 2;

    logic [1:0]             state;
    logic [memory_addr-1:0] pc;
    logic                   inflight;   // response arrives on IDATA this cycle
    logic [AW:0]            occ;
    logic                   buf_full, buf_empty;
    logic                   pop, push, room, halt_hit;

    assign pop  = I_VLD && I_RDY;
    // A redirect discards the response that arrives with it.
    assign push = inflight && !JMP_EN;

`ifdef FETCH_HALT_EN
    assign halt_hit = push && is_halt(IDATA[word_size-1 -: 4]);
    assign HALTED   = (state == ST_HALT);
`else
    assign halt_hit = 1'b0;
    assign HALTED   = 1'b0;
`endif

    // Slot reservation: buffered + in-flight + the new request must fit,
    // counting a dequeue in this same cycle.
    assign room = inflight ? ((CW'(occ) + CW'(2)) <= (CW'(buf_depth) + CW'(pop)))
                           : (!buf_full || pop);

    // Blocking on halt_hit stops the request following the HALT word.
    assign IREQ  = (state == ST_RUN) && room && !JMP_EN && !halt_hit;
    assign IADDR = pc;
    assign I_VLD = !buf_empty;

    always_ff @(posedge DCLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            pc       <= reset_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= IREQ;
            if (JMP_EN)    pc <= JMP_TARGET;
            else if (IREQ) pc <= pc + memory_addr'(1);
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN:  if (halt_hit) state <= ST_HALT;
                ST_HALT: if (JMP_EN)   state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .W     (word_size),
        .DEPTH (buf_depth)
    ) u_buf (
        .clk   (DCLK),
        .rst_n (RST_N),
        .push  (push),
        .din   (IDATA),
        .pop   (pop),
        .flush (JMP_EN),
        .dout  (I_OUT),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occ)
    );

endmodule
